// File: rtl/lsu_defer_buffer.sv
// Issue-stage defer buffer: parks instructions in a small FIFO and lets independent
// non-memory instructions bypass a head load/store that is stalled on the LSU.
package lsu_defer_buffer_pkg;
    typedef enum logic [2:0] {
        FU_NONE, FU_LOAD, FU_STORE, FU_ALU, FU_CTRL_FLOW, FU_MULT, FU_CSR
    } fu_t;

    typedef struct packed {
        logic [7:0] tag;
        fu_t        fu;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } scoreboard_entry_t;
endpackage

module lsu_defer_buffer
    import lsu_defer_buffer_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int MAX_BYPASS = 4,
    parameter bit BYPASS_EN  = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       debug_req_i,
    input  scoreboard_entry_t          issue_entry_i,
    input  logic                       issue_entry_valid_i,
    input  logic                       is_ctrl_flow_i,
    output logic                       issue_instr_ack_o,
    output scoreboard_entry_t          issue_entry_o,
    output logic                       issue_entry_valid_o,
    output logic                       is_ctrl_flow_o,
    input  logic                       issue_instr_ack_i,
    input  logic                       lsu_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       bypass_o
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int BCNT_W = $clog2(MAX_BYPASS + 1);

    typedef struct packed {
        scoreboard_entry_t sbe;
        logic              valid;
        logic              is_ctrl_flow;
    } fifo_entry_t;

    fifo_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [BCNT_W-1:0] byp_cnt_q, byp_cnt_d;

    fifo_entry_t head;
    logic        empty, full, skip_in, hazard, bypass, push, pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Register index 0 is hardwired, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    assign head    = mem_q[head_q];
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign skip_in = is_ctrl_flow_i || (issue_entry_i.fu == FU_CSR);

    // Only slots between head and tail hold live entries; stale slots are ignored.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            int                off;
            scoreboard_entry_t e;
            off = i - int'(head_q);
            if (off < 0) off = off + DEPTH;
            e = mem_q[i].sbe;
            if (off < int'(count_q)) begin
                if (e.fu == FU_LOAD && (reg_match(issue_entry_i.rs1, e.rd) ||
                                        reg_match(issue_entry_i.rs2, e.rd) ||
                                        reg_match(issue_entry_i.rd, e.rd)))
                    hazard = 1'b1;
                if (reg_match(issue_entry_i.rd, e.rs1) ||
                    (e.fu == FU_STORE && reg_match(issue_entry_i.rd, e.rs2)))
                    hazard = 1'b1;
            end
        end
    end

    assign bypass = BYPASS_EN && !debug_req_i && !empty && !lsu_ready_i
                 && (head.sbe.fu inside {FU_LOAD, FU_STORE})
                 && issue_entry_valid_i
                 && !(issue_entry_i.fu inside {FU_LOAD, FU_STORE, FU_CTRL_FLOW, FU_CSR})
                 && (byp_cnt_q < BCNT_W'(MAX_BYPASS))
                 && !hazard;

    // NOTE: every signal driven here gets a default first so no path infers a latch.
    always_comb begin
        head_d              = head_q;
        tail_d              = tail_q;
        count_d             = count_q;
        byp_cnt_d           = byp_cnt_q;
        push                = 1'b0;
        pop                 = 1'b0;
        issue_entry_o       = issue_entry_i;
        issue_entry_valid_o = 1'b0;
        is_ctrl_flow_o      = 1'b0;
        issue_instr_ack_o   = 1'b0;
        bypass_o            = 1'b0;
        count_o             = rst_i ? '0 : count_q;

        if (rst_i) begin
            // outputs stay quiet; state is cleared by the register process
        end else if (flush_i) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            byp_cnt_d = '0;
        end else if (empty) begin
            issue_entry_valid_o = issue_entry_valid_i;
            is_ctrl_flow_o      = is_ctrl_flow_i;
            push                = issue_entry_valid_i && !issue_instr_ack_i && !skip_in;
            issue_instr_ack_o   = issue_entry_valid_i && (issue_instr_ack_i || !skip_in);
        end else if (bypass) begin
            issue_entry_valid_o = 1'b1;
            is_ctrl_flow_o      = is_ctrl_flow_i;
            issue_instr_ack_o   = issue_instr_ack_i;
            bypass_o            = 1'b1;
            if (issue_instr_ack_i && byp_cnt_q != BCNT_W'(MAX_BYPASS))
                byp_cnt_d = byp_cnt_q + 1'b1;
        end else begin
            issue_entry_o       = head.sbe;
            issue_entry_valid_o = head.valid;
            is_ctrl_flow_o      = head.is_ctrl_flow;
            pop                 = issue_instr_ack_i;
            push                = issue_entry_valid_i && !skip_in && (!full || pop);
            issue_instr_ack_o   = push;
        end

        if (!rst_i && !flush_i) begin
            if (push) tail_d = next_ptr(tail_q);
            if (pop)  head_d = next_ptr(head_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (pop || count_d == '0) byp_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            byp_cnt_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            byp_cnt_q <= byp_cnt_d;
        end
    end

    // NOTE: storage is not reset; the count alone decides which slots are live.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[tail_q] <= '{sbe: issue_entry_i, valid: issue_entry_valid_i,
                                     is_ctrl_flow: is_ctrl_flow_i};
    end
endmodule
